// File: rtl/rr_stage_arb_if.sv
// Requester/downstream bundle for rr_stage_arb. The lock request vector exists
// only when RR_STAGE_ARB_LOCK_EN is defined.
interface rr_stage_arb_if #(
  parameter int WIDTH = 14,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_src;
  logic                  out_ready;
`ifdef RR_STAGE_ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;

  modport slave (
    input  req_valid, req_data, req_lock, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport master (
    output req_valid, req_data, req_lock, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`endif
endinterface

// File: rtl/rr_stage_arb.sv
// Round-robin arbiter feeding one shared WIDTH-bit stage register with valid/ready.
// Define RR_STAGE_ARB_LOCK_EN to add per-requester lock (burst ownership of the stage).
module rr_stage_arb #(
  parameter int WIDTH = 14,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst_l,
  rr_stage_arb_if.slave  bus
);
  localparam int IDXW = IDW + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_src_q, out_src_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
`ifdef RR_STAGE_ARB_LOCK_EN
  logic             lock_valid_q, lock_valid_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
`endif

  logic             load;
  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  accept;
  logic [WIDTH-1:0] req_word [NREQ];
  logic             any_acc;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   gnt_inc;

  assign load = rst_l & (~out_valid_q | bus.out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
      assign accept[gi]   = bus.req_valid[gi] & ready[gi];
    end
  endgenerate

  // ready[i] means "no valid requester ahead of i in the rotated order", so a
  // requester's own valid never feeds its own ready; valid&ready stays one-hot.
  always_comb begin
    logic             seen;
    logic [IDXW-1:0]  idx;
    ready = '0;
    seen  = 1'b0;
    idx   = '0;
    for (int m = 0; m < NREQ; m++) begin
      idx = IDXW'(ptr_q) + IDXW'(m);
      if (idx >= IDXW'(NREQ)) idx = idx - IDXW'(NREQ);
      ready[idx[IDW-1:0]] = load & ~seen;
      seen = seen | bus.req_valid[idx[IDW-1:0]];
    end
`ifdef RR_STAGE_ARB_LOCK_EN
    if (lock_valid_q) begin
      ready = '0;
      ready[lock_id_q] = load;
    end
`endif
  end

  always_comb begin
    any_acc = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        any_acc = 1'b1;
        gnt     = IDW'(i);
      end
    end
    gnt_inc = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
`ifdef RR_STAGE_ARB_LOCK_EN
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
`endif
    if (load) begin
      out_valid_d = any_acc;
      if (any_acc) begin
        out_data_d = req_word[gnt];
        out_src_d  = gnt;
`ifdef RR_STAGE_ARB_LOCK_EN
        // Pointer is frozen during a locked burst and resumes after its owner.
        if (lock_valid_q) begin
          if (!bus.req_lock[gnt]) begin
            lock_valid_d = 1'b0;
            ptr_d        = gnt_inc;
          end
        end else begin
          ptr_d = gnt_inc;
          if (bus.req_lock[gnt]) begin
            lock_valid_d = 1'b1;
            lock_id_d    = gnt;
          end
        end
`else
        ptr_d = gnt_inc;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_STAGE_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
`ifdef RR_STAGE_ARB_LOCK_EN
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_stage_arb.sv
// Directed bench for rr_stage_arb: reset, fairness, backpressure, wrap/skip,
// async mid-transfer reset, single requester and (when enabled) lock bursts.
module tb_rr_stage_arb;
  localparam int W = 14;
  localparam int N = 4;

  logic clk;
  logic rst_l;
  int   n_checks;
  int   n_fail;

  rr_stage_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

  rr_stage_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t out_valid=%0b out_src=%0d out_data=%h req_ready=%b",
             $time, bus.out_valid, bus.out_src, bus.out_data, bus.req_ready);
  endtask

  task automatic expect_out(input string tag, input int src, input logic [W-1:0] data);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_src"},   32'(bus.out_src),   32'(src));
    chk({tag, "_data"},  32'(bus.out_data),  32'(data));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_l         = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
`ifdef RR_STAGE_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    for (int i = 0; i < N; i++) set_data(i, W'(14'h100 + i));

    // Reset held with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_src",   32'(bus.out_src),   32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_l = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);

    // Fairness: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out($sformatf("fair%0d", k), k % N, W'(14'h100 + (k % N)));
    end

    // Load src 2 with 14'h3A5, then stall with req 1 waiting
    bus.req_valid = 4'b0100;
    set_data(2, 14'h3A5);
    step();
    expect_out("bp_load", 2, 14'h3A5);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    set_data(1, 14'h2C7);
    #1;
    chk("bp_ready0", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_ready_c%0d", k), 32'(bus.req_ready), 32'd0);
      expect_out($sformatf("bp_hold%0d", k), 2, 14'h3A5);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_grant1", 32'(bus.req_ready & bus.req_valid), 32'b0010);
    step();
    expect_out("bp_drain", 1, 14'h2C7);

    // ptr is now 2: reqs 0 and 3 valid -> 3 first, then 0
    bus.req_valid = 4'b1001;
    set_data(0, 14'h011);
    set_data(3, 14'h333);
    #1;
    chk("skip_grant3", 32'(bus.req_ready & bus.req_valid), 32'b1000);
    step();
    expect_out("skip_src3", 3, 14'h333);
    step();
    expect_out("wrap_src0", 0, 14'h011);

    // Idle: stage empties, contents held
    bus.req_valid = '0;
    step();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_data",  32'(bus.out_data),  32'(14'h011));
    chk("idle_src",   32'(bus.out_src),   32'd0);

    // Async reset between edges drops a pending beat
    bus.req_valid = 4'b0010;
    step();
    expect_out("mid_load", 1, 14'h2C7);
    bus.out_ready = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'd0);
    chk("mid_rst_src",   32'(bus.out_src),   32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    rst_l = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("mid_ptr0_ready", 32'(bus.req_ready), 32'b0001);
    step();
    expect_out("mid_restart", 0, 14'h011);

    // Single requester granted every cycle regardless of ptr
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out($sformatf("single%0d", k), 2, 14'h3A5);
    end

`ifdef RR_STAGE_ARB_LOCK_EN
    // Move ptr to 2, then req 2 bursts with lock 1,1,0 while req 0 waits
    bus.req_valid = 4'b0010;
    step();
    expect_out("lk_pre", 1, 14'h2C7);
    bus.req_valid = 4'b0101;
    bus.req_lock  = 4'b0100;
    step();
    expect_out("lk_b0", 2, 14'h3A5);
    chk("lk_ready_locked", 32'(bus.req_ready), 32'b0100);
    step();
    expect_out("lk_b1", 2, 14'h3A5);
    bus.req_lock = 4'b0000;
    step();
    expect_out("lk_b2", 2, 14'h3A5);
    bus.req_valid = 4'b0001;
    step();
    expect_out("lk_after", 0, 14'h011);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_stage_arb.md
Name: rr_stage_arb

Overview:
- Round-robin arbiter that shares one WIDTH-bit pipeline staging register among NREQ requesters.
- Each cycle it picks at most one valid requester, captures its data and source ID into the stage register, and presents it downstream with a valid/ready handshake.
- It sits in front of shared single-register datapath stages in the core, such as writeback or trace capture, where several units compete for one flop stage.

Parameters:
- WIDTH, 14, data width of each requester and of the stage register.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the source ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_l  input  1  reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot or zero; requester i is accepted when req_valid[i] & req_ready[i].
- out_valid  output  1  stage register holds data.
- out_data  output  WIDTH  stage register contents.
- out_src  output  IDW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data when out_valid & out_ready.

Interface rule (already decided): one clock; reset is asynchronous and active-low; ports are named clk and rst_l.

Behaviour:
- Reset (rst_l low, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - req_ready combinationally 0 while rst_l is low.
- Stage load enable: load = ~out_valid | out_ready. This gives full throughput, one transfer per cycle.
- Grant is combinational:
  - When load=1, grant goes to the first i with req_valid[i]=1, searching from ptr upward with wrap-around (ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1).
  - req_ready = one-hot grant.
  - When load=0, req_ready=0.
- req_ready never depends on req_valid of the same requester. It depends only on other requesters' valids, ptr and load, so there is no combinational loop with requesters that wait for ready.
- On a rising edge with load=1 and any grant (requester g):
  - out_data <= req_data[g], out_src <= g, out_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- On a rising edge with load=1 and no valid requester:
  - out_valid <= 0; ptr unchanged.
  - out_data and out_src hold their previous values (don't-care, but must not be X).
- On a rising edge with load=0 (stalled): all state holds.
- Latency: accepted data appears on out_data the cycle after acceptance.
- Simultaneous drain and fill (out_valid=1, out_ready=1, new grant): the new data replaces the old in the same edge, with no bubble.
- Single requester: with only one valid requester, it is granted every load cycle regardless of ptr.
- Fairness: with all NREQ requesters valid and no stalls, each is granted exactly once per NREQ consecutive transfers.
- Reset asserted mid-transfer: the stage is cleared immediately and the in-flight beat is dropped. After reset release, arbitration restarts at ptr=0.
- No internal FSM beyond the stage valid bit and ptr; total flops = WIDTH + IDW + 1 + IDW.

Optional Feature:
- Macro: RR_STAGE_ARB_LOCK_EN.
- When defined:
  - An extra input port req_lock [NREQ] is present, plus an internal lock_valid flag and lock_id register (reset 0).
  - Accepting from requester g with req_lock[g]=1 sets lock_valid=1 and lock_id=g.
  - While lock_valid=1, only lock_id may be granted; other requesters see req_ready=0 even if lock_id is not valid that cycle. ptr does not advance while locked.
  - Accepting a beat from lock_id with req_lock=0 clears lock_valid and sets ptr=(lock_id+1) mod NREQ.
  - Reset clears the lock.
- When not defined: the req_lock port and lock logic are absent, and arbitration is purely round-robin as above.

Test Plan:
- Reset: hold rst_l=0 with all req_valid=1 -> out_valid=0, out_data=0, req_ready=0. After release, first grant goes to requester 0.
- Fairness: NREQ=4, all valid, data[i]=14'h100+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_data matches each source.
- Backpressure: stage holds 14'h3A5 from src 2, out_ready=0 for 3 cycles with req 1 valid -> req_ready=0 and out_data stable at 14'h3A5. When out_ready=1, req 1 is granted and out_data=its data next cycle.
- Wrap and skip: ptr=3, only req 1 valid -> req 1 granted, ptr becomes 2. Then only reqs 0 and 3 valid -> req 3 granted first.
- Mid-operation reset: out_valid=1 with src 1 pending, rst_l pulsed low between edges -> out_valid drops immediately without a clock; ptr=0 afterwards.
- Lock (RR_STAGE_ARB_LOCK_EN): req 2 sends 3 beats with lock=1,1,0 while req 0 is continuously valid -> out_src=2,2,2, then 0.
